// File: rtl/iram_ctrl_pkg.sv
// Shared constants and types for the instruction RAM refill controller.
package iram_ctrl_pkg;

  localparam int IRAM_PC_SIZE    = 32;
  localparam int IRAM_WORD_SIZE  = 32;
  localparam int IRAM_LINE_WORDS = 4;
  localparam int IRAM_LATENCY    = 2;
  localparam int IRAM_DEPTH_LOG  = 10;

  typedef enum logic [1:0] {
    IRAM_IDLE,
    IRAM_WAIT,
    IRAM_BURST,
    IRAM_RELEASE
  } iram_state_t;

endpackage

// File: rtl/iram_array.sv
// Instruction memory: one synchronous read port, one synchronous write port.
// A read and a write to the same word in one cycle return the old contents.
module iram_array #(
  parameter int DEPTH_LOG = 10,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rd_en,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data
);

  logic [WORD_SIZE-1:0] mem [2**DEPTH_LOG];

  // Write port.
  // NOTE: the storage array has no reset; program contents must survive nrst and a reset loop would stop it mapping to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port; the register holds its value when not enabled.
  // NOTE: non-blocking assignments here give read-old-data on a same-word collision with the write port.
  always_ff @(posedge clk) begin
    if (!nrst)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/iram_ctrl.sv
// Instruction-miss refill responder: on i_miss, streams one cache line from
// the internal memory one word per cycle, plus a program-load write port.
module iram_ctrl
  import iram_ctrl_pkg::*;
#(
  parameter int PC_SIZE     = IRAM_PC_SIZE,
  parameter int WORD_SIZE   = IRAM_WORD_SIZE,
  parameter int LINE_WORDS  = IRAM_LINE_WORDS,
  parameter int MEM_LATENCY = IRAM_LATENCY,
  parameter int DEPTH_LOG   = IRAM_DEPTH_LOG
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          i_miss,
  input  logic [PC_SIZE-1:0]            ram_address,
  output logic [WORD_SIZE-1:0]          mem_word,
  output logic                          word_ready,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx,
  output logic                          busy,
  input  logic                          load_en,
  input  logic [PC_SIZE-1:0]            load_addr,
  input  logic [WORD_SIZE-1:0]          load_data
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = DEPTH_LOG - IDX_W;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  iram_state_t          state;
  logic [LAT_W-1:0]     lat_cnt;
  logic [TAG_W-1:0]     line_tag;
  logic                 rd_en;
  logic [IDX_W-1:0]     rd_idx;
  logic [DEPTH_LOG-1:0] rd_addr;
  logic [DEPTH_LOG-1:0] wr_addr;

  // Byte offset and address bits above the memory depth are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_address[PC_SIZE-1:DEPTH_LOG+2], ram_address[IDX_W+1:0],
                              load_addr[PC_SIZE-1:DEPTH_LOG+2], load_addr[1:0]};

  // Issue the memory read for the word that goes out after the coming edge.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = '0;
    case (state)
      IRAM_WAIT:  rd_en = i_miss && (lat_cnt == '0);
      IRAM_BURST: begin
        rd_en  = i_miss && (word_idx != LAST_IDX);
        rd_idx = word_idx + 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_addr = {line_tag, rd_idx};
  assign wr_addr = load_addr[DEPTH_LOG+1:2];
  assign busy    = (state != IRAM_IDLE);

  // Refill FSM. WAIT always carries the latency count, including the
  // single-cycle case (count starts at 0), so the first word lands exactly
  // MEM_LATENCY edges after acceptance. word_ready is high only in BURST.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IRAM_IDLE;
      lat_cnt    <= '0;
      line_tag   <= '0;
      word_ready <= 1'b0;
      word_idx   <= '0;
    end else begin
      case (state)
        IRAM_IDLE: begin
          word_ready <= 1'b0;
          if (i_miss) begin
            line_tag <= ram_address[DEPTH_LOG+1:IDX_W+2];
            lat_cnt  <= LAT_INIT;
            state    <= IRAM_WAIT;
          end
        end
        IRAM_WAIT: begin
          if (!i_miss) begin
            state <= IRAM_IDLE;
          end else if (lat_cnt == '0) begin
            state      <= IRAM_BURST;
            word_ready <= 1'b1;
            word_idx   <= '0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        IRAM_BURST: begin
          if (!i_miss) begin
            state      <= IRAM_IDLE;
            word_ready <= 1'b0;
          end else if (word_idx == LAST_IDX) begin
            state      <= IRAM_RELEASE;
            word_ready <= 1'b0;
          end else begin
            word_idx <= word_idx + 1'b1;
          end
        end
        IRAM_RELEASE: begin
          word_ready <= 1'b0;
          if (!i_miss) state <= IRAM_IDLE;
        end
        default: state <= IRAM_IDLE;
      endcase
    end
  end

  iram_array #(
    .DEPTH_LOG (DEPTH_LOG),
    .WORD_SIZE (WORD_SIZE)
  ) u_array (
    .clk     (clk),
    .nrst    (nrst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (mem_word),
    .wr_en   (load_en),
    .wr_addr (wr_addr),
    .wr_data (load_data)
  );

endmodule
